// File: rtl/act_pipe_pkg.sv
// Shared types and PWL sigmoid constants for the activation pipeline.
// Breakpoints and offsets scale with the fraction width (FRAC >= 5).
package act_pipe_pkg;

  typedef struct packed {
    int unsigned prec;
  } dconf_t;

  localparam dconf_t DEF_DCONF_C = '{prec: 32'd16};

  typedef enum logic [1:0] {
    STEP    = 2'd0,
    LINEAR  = 2'd1,
    ReLU    = 2'd2,
    SIGMOID = 2'd3
  } actf_t;

  typedef enum logic [1:0] {
    SEG_LO  = 2'd0,
    SEG_MID = 2'd1,
    SEG_HI  = 2'd2,
    SEG_SAT = 2'd3
  } pwl_seg_t;

  // Breakpoints: 5.0, 2.375 (19/8), 1.0
  function automatic int unsigned pwl_bp_sat(input int unsigned frac);
    return 32'd5 << frac;
  endfunction

  function automatic int unsigned pwl_bp_hi(input int unsigned frac);
    return 32'd19 << (frac - 32'd3);
  endfunction

  function automatic int unsigned pwl_bp_mid(input int unsigned frac);
    return 32'd1 << frac;
  endfunction

  // Offsets: 0.84375 (27/32), 0.625 (5/8), 0.5
  function automatic int unsigned pwl_off_hi(input int unsigned frac);
    return 32'd27 << (frac - 32'd5);
  endfunction

  function automatic int unsigned pwl_off_mid(input int unsigned frac);
    return 32'd5 << (frac - 32'd3);
  endfunction

  function automatic int unsigned pwl_off_lo(input int unsigned frac);
    return 32'd1 << (frac - 32'd1);
  endfunction

endpackage

// File: rtl/act_sigmoid_pwl.sv
// Single-lane shift-add piecewise-linear sigmoid; purely combinational.
// Evaluates the positive half on |x| and mirrors it as 1.0 - y for negative x.
module act_sigmoid_pwl
  import act_pipe_pkg::*;
#(
  parameter int unsigned PREC = 16,
  parameter int unsigned FRAC = 8
) (
  input  logic            sign,
  input  logic [PREC-1:0] mag,
  input  pwl_seg_t        seg,
  output logic [PREC-1:0] y
);

  localparam logic [PREC-1:0] ONE     = PREC'(32'd1 << FRAC);
  localparam logic [PREC-1:0] OFF_HI  = PREC'(pwl_off_hi(FRAC));
  localparam logic [PREC-1:0] OFF_MID = PREC'(pwl_off_mid(FRAC));
  localparam logic [PREC-1:0] OFF_LO  = PREC'(pwl_off_lo(FRAC));

  logic [PREC-1:0] pos;

  always_comb begin
    pos = ONE;
    case (seg)
      SEG_SAT: pos = ONE;
      SEG_HI:  pos = (mag >> 5) + OFF_HI;
      SEG_MID: pos = (mag >> 3) + OFF_MID;
      default: pos = (mag >> 2) + OFF_LO;
    endcase
    y = sign ? (ONE - pos) : pos;
  end

endmodule

// File: rtl/act_pipe.sv
// Two-stage multi-lane activation unit with valid/ready handshake.
// Define ACT_SIGMOID_EN to build the PWL sigmoid; otherwise SIGMOID acts as LINEAR.
`ifndef DEF_DCONF
`define DEF_DCONF act_pipe_pkg::DEF_DCONF_C
`endif

module act_pipe
  import act_pipe_pkg::*;
#(
  parameter dconf_t      CONF  = `DEF_DCONF,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned LANES = 4
) (
  input  logic                         clk,
  input  logic                         reset_,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  actf_t                        in_mode,
  input  logic [LANES*CONF.prec-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*CONF.prec-1:0]   out_data,
  output logic                         busy
);

  localparam int unsigned P = CONF.prec;
  localparam int unsigned W = LANES * P;
  localparam logic [P-1:0] ONE = P'(32'd1 << FRAC);

  logic s1_v, s2_v;
  logic s1_load, s2_load;
  logic s1_v_nxt, s2_v_nxt;

  actf_t        s1_mode;
  logic [P-1:0] s1_x [LANES];
  logic [P-1:0] res_c [LANES];
  logic [W-1:0] res_flat;

  // Handshake: in_ready follows out_ready combinationally through s2_load
  always_comb begin
    s2_load  = !s2_v || out_ready;
    s1_load  = !s1_v || s2_load;
    s1_v_nxt = s1_load ? in_valid : s1_v;
    s2_v_nxt = s2_load ? s1_v : s2_v;
  end

  assign in_ready  = s1_load;
  assign out_valid = s2_v;

`ifdef ACT_SIGMOID_EN
  localparam logic [P-1:0] MAXP   = {1'b0, {(P-1){1'b1}}};
  localparam logic [P-1:0] MINN   = {1'b1, {(P-1){1'b0}}};
  localparam logic [P-1:0] BP_SAT = P'(pwl_bp_sat(FRAC));
  localparam logic [P-1:0] BP_HI  = P'(pwl_bp_hi(FRAC));
  localparam logic [P-1:0] BP_MID = P'(pwl_bp_mid(FRAC));

  logic [P-1:0] in_mag [LANES];
  pwl_seg_t     in_seg [LANES];
  logic [P-1:0] s1_mag [LANES];
  pwl_seg_t     s1_seg [LANES];
  logic [P-1:0] sig_y  [LANES];

  // |x| with the most negative value saturated, then segment select
  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      in_mag[i] = in_data[i*P +: P];
      if (in_data[i*P + P - 1]) begin
        in_mag[i] = (in_data[i*P +: P] == MINN) ? MAXP : (~in_data[i*P +: P] + P'(1));
      end
      if (in_mag[i] >= BP_SAT)      in_seg[i] = SEG_SAT;
      else if (in_mag[i] >= BP_HI)  in_seg[i] = SEG_HI;
      else if (in_mag[i] >= BP_MID) in_seg[i] = SEG_MID;
      else                          in_seg[i] = SEG_LO;
    end
  end

  for (genvar g = 0; g < int'(LANES); g++) begin : g_sig
    act_sigmoid_pwl #(.PREC(P), .FRAC(FRAC)) u_sig (
      .sign (s1_x[g][P-1]),
      .mag  (s1_mag[g]),
      .seg  (s1_seg[g]),
      .y    (sig_y[g])
    );
  end
`endif

  // Stage 1: capture data and mode with the transaction
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      s1_v    <= 1'b0;
      s1_mode <= LINEAR;
      for (int i = 0; i < int'(LANES); i++) begin
        s1_x[i] <= '0;
`ifdef ACT_SIGMOID_EN
        s1_mag[i] <= '0;
        s1_seg[i] <= SEG_LO;
`endif
      end
    end else begin
      s1_v <= s1_v_nxt;
      if (s1_load && in_valid) begin
        s1_mode <= in_mode;
        for (int i = 0; i < int'(LANES); i++) begin
          s1_x[i] <= in_data[i*P +: P];
`ifdef ACT_SIGMOID_EN
          s1_mag[i] <= in_mag[i];
          s1_seg[i] <= in_seg[i];
`endif
        end
      end
    end
  end

  // Per-lane function select; unknown modes fall through to LINEAR
  always_comb begin
    res_flat = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      res_c[i] = s1_x[i];
      case (s1_mode)
        STEP:    res_c[i] = s1_x[i][P-1] ? '0 : ONE;
        LINEAR:  res_c[i] = s1_x[i];
        ReLU:    res_c[i] = s1_x[i][P-1] ? '0 : s1_x[i];
`ifdef ACT_SIGMOID_EN
        SIGMOID: res_c[i] = sig_y[i];
`endif
        default: res_c[i] = s1_x[i];
      endcase
      res_flat[i*P +: P] = res_c[i];
    end
  end

  // Stage 2: registered results; held while downstream stalls
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      s2_v     <= 1'b0;
      out_data <= '0;
      busy     <= 1'b0;
    end else begin
      s2_v <= s2_v_nxt;
      busy <= s1_v_nxt || s2_v_nxt;
      if (s2_load && s1_v) begin
        out_data <= res_flat;
      end
    end
  end

endmodule

// File: tb/tb_act_pipe.sv
// Self-checking bench for act_pipe: vector table plus scoreboard, stall and reset sequences.
module tb_act_pipe;
  import act_pipe_pkg::*;

  localparam int unsigned P = 16;
  localparam int unsigned L = 4;
  localparam int unsigned W = P * L;

  logic         clk = 1'b0;
  logic         reset_ = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  actf_t        in_mode = LINEAR;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         busy;

  always #5 clk = ~clk;

  act_pipe #(.FRAC(8), .LANES(4)) dut (
    .clk       (clk),
    .reset_    (reset_),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  typedef struct {
    actf_t        mode;
    logic [W-1:0] data;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         vecs [6];
  logic [W-1:0] sb [$];
  int           tests = 0;
  int           fails = 0;
  int           stalls = 0;
  logic [W-1:0] hold;

  function automatic logic [W-1:0] pack4(input logic [15:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [W-1:0] sig_or_lin(input logic [W-1:0] sig, input logic [W-1:0] d);
`ifdef ACT_SIGMOID_EN
    return sig | (d & '0);
`else
    return d | (sig & '0);
`endif
  endfunction

  // Reference model of one lane (1.0 = 256)
  function automatic logic [15:0] model(input actf_t m, input logic [15:0] x);
    int v, a, y;
    v = int'($signed(x));
    case (m)
      STEP:    return (v >= 0) ? 16'h0100 : 16'h0000;
      ReLU:    return (v < 0) ? 16'h0000 : x;
      SIGMOID: begin
`ifdef ACT_SIGMOID_EN
        a = (v < 0) ? ((v == -32768) ? 32767 : -v) : v;
        if (a >= 1280)     y = 256;
        else if (a >= 608) y = a / 32 + 216;
        else if (a >= 256) y = a / 8 + 160;
        else               y = a / 4 + 128;
        if (v < 0) y = 256 - y;
        return 16'(y);
`else
        return x;
`endif
      end
      default: return x;
    endcase
  endfunction

  function automatic logic [W-1:0] model4(input actf_t m, input logic [W-1:0] d);
    logic [W-1:0] r;
    for (int i = 0; i < int'(L); i++) r[i*P +: P] = model(m, d[i*P +: P]);
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard pop on each output transfer
  task automatic half_neg();
    @(negedge clk);
    if (reset_ && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %h expected no output", out_data);
      end else begin
        check("out_data", out_data, sb.pop_front());
      end
    end
  endtask

  task automatic half_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input actf_t m, input logic [W-1:0] d, input logic [W-1:0] e);
    int waits;
    waits = 0;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    half_neg();
    while (!in_ready && waits < 50) begin
      half_pos();
      half_neg();
      waits++;
    end
    tests++;
    if (!in_ready) begin
      fails++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
    end else begin
      sb.push_back(e);
    end
    stalls += waits;
    half_pos();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      half_neg();
      half_pos();
      n++;
    end
    check("drain_left", W'(sb.size()), '0);
  endtask

  initial begin
    logic [W-1:0] d, e;
    actf_t m;

    vecs[0] = '{SIGMOID, pack4(16'h0000, 16'h0100, 16'hFF00, 16'h0600),
                sig_or_lin(pack4(16'h0080, 16'h00C0, 16'h0040, 16'h0100),
                           pack4(16'h0000, 16'h0100, 16'hFF00, 16'h0600))};
    vecs[1] = '{ReLU, pack4(16'hFD00, 16'h0280, 16'h0000, 16'h8000),
                pack4(16'h0000, 16'h0280, 16'h0000, 16'h0000)};
    vecs[2] = '{STEP, pack4(16'hFD00, 16'h0280, 16'h0000, 16'h8000),
                pack4(16'h0000, 16'h0100, 16'h0100, 16'h0000)};
    vecs[3] = '{LINEAR, pack4(16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF),
                pack4(16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF)};
    vecs[4] = '{SIGMOID, pack4(16'h0500, 16'h04FF, 16'h0260, 16'h025F),
                sig_or_lin(pack4(16'h0100, 16'h00FF, 16'h00EB, 16'h00EB),
                           pack4(16'h0500, 16'h04FF, 16'h0260, 16'h025F))};
    vecs[5] = '{SIGMOID, pack4(16'h8000, 16'hFB00, 16'hFF01, 16'h00FF),
                sig_or_lin(pack4(16'h0000, 16'h0000, 16'h0041, 16'h00BF),
                           pack4(16'h8000, 16'hFB00, 16'hFF01, 16'h00FF))};

    // Reset state
    #1 reset_ = 1'b0;
    #2;
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_busy", W'(busy), '0);
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_data", out_data, '0);
    repeat (2) @(posedge clk);
    #1 reset_ = 1'b1;
    out_ready = 1'b1;

    // Vector table, with a latency check on the first one
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].mode, vecs[i].data, vecs[i].exp);
      if (i == 0) begin
        check("lat_edge_n", W'(out_valid), '0);
        half_neg();
        half_pos();
        check("lat_edge_n1", W'(out_valid), W'(1));
      end
      drain();
    end

    // Back-to-back, alternating LINEAR / ReLU
    stalls = 0;
    for (int k = 0; k < 8; k++) begin
      m = (k % 2 == 1) ? ReLU : LINEAR;
      d = {$urandom, $urandom};
      send(m, d, model4(m, d));
    end
    check("b2b_stalls", W'(stalls), '0);
    drain();

    // Backpressure: two accepted, third blocked, output held
    out_ready = 1'b0;
    d = pack4(16'h0101, 16'hFF80, 16'h0020, 16'h8001);
    in_valid = 1'b1; in_mode = LINEAR; in_data = d;
    half_neg();
    check("bp_rdy1", W'(in_ready), W'(1));
    sb.push_back(model4(LINEAR, d));
    half_pos();
    d = pack4(16'hF000, 16'h0300, 16'h0001, 16'h7000);
    in_mode = ReLU; in_data = d;
    half_neg();
    check("bp_rdy2", W'(in_ready), W'(1));
    sb.push_back(model4(ReLU, d));
    half_pos();
    d = pack4(16'hFFFF, 16'h0000, 16'h0400, 16'h8000);
    in_mode = STEP; in_data = d;
    half_neg();
    check("bp_rdy3_blocked", W'(in_ready), '0);
    check("bp_out_valid", W'(out_valid), W'(1));
    hold = out_data;
    for (int k = 0; k < 2; k++) begin
      half_pos();
      half_neg();
      check("bp_hold_data", out_data, hold);
      check("bp_hold_ready", W'(in_ready), '0);
      check("bp_busy", W'(busy), W'(1));
    end
    half_pos();
    out_ready = 1'b1;
    half_neg();
    check("bp_release_ready", W'(in_ready), W'(1));
    sb.push_back(model4(STEP, d));
    half_pos();
    in_valid = 1'b0;
    drain();

    // Reset with both stages full
    out_ready = 1'b0;
    send(LINEAR, pack4(16'h1111, 16'h2222, 16'h3333, 16'h4444),
         pack4(16'h1111, 16'h2222, 16'h3333, 16'h4444));
    send(LINEAR, pack4(16'h5555, 16'h6666, 16'h7777, 16'h0888),
         pack4(16'h5555, 16'h6666, 16'h7777, 16'h0888));
    check("full_busy", W'(busy), W'(1));
    reset_ = 1'b0;
    #1;
    check("mid_rst_out_valid", W'(out_valid), '0);
    check("mid_rst_busy", W'(busy), '0);
    check("mid_rst_in_ready", W'(in_ready), W'(1));
    sb.delete();
    half_neg();
    half_pos();
    reset_ = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      half_neg();
      check("post_rst_no_output", W'(out_valid), '0);
      half_pos();
    end
    d = pack4(16'h0042, 16'hFF00, 16'h0100, 16'h0000);
    send(SIGMOID, d, model4(SIGMOID, d));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
